// File: rtl/multicycle_sub_128_if.sv
// Handshake and operand/result bundle for the multicycle 128-bit subtractor.
// The master drives the request and operands; the slave returns the result and flags.
interface multicycle_sub_128_if;
    logic         start;
    logic [127:0] a;
    logic [127:0] b;
    logic [127:0] diff;
    logic         borrow;
    logic         zero;
    logic         busy;
    logic         done;

    modport master (
        output start, a, b,
        input  diff, borrow, zero, busy, done
    );

    modport slave (
        input  start, a, b,
        output diff, borrow, zero, busy, done
    );
endinterface

// File: rtl/multicycle_sub_128.sv
// 128-bit subtractor computing a - b over four cycles with one shared 32-bit add slice.
// Subtraction is done as a + ~b + 1, so the slice carry chain starts at 1.
// The final carry-out is the inverse of the unsigned borrow.
module multicycle_sub_128 #(
    parameter int SLICE_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    multicycle_sub_128_if.slave   bus
);

    localparam int NSLICE = 128 / SLICE_W;
    localparam int KW     = $clog2(NSLICE);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state;
    state_t state_next;

    logic [KW-1:0]    k;
    logic             carry;
    logic [127:0]     a_q;
    logic [127:0]     b_q;
    logic [127:0]     diff_q;
    logic             borrow_q;
    logic             zero_q;
    logic             busy_q;
    logic             done_q;

    logic [SLICE_W-1:0] a_slice;
    logic [SLICE_W-1:0] b_slice;
    logic [SLICE_W:0]   slice_sum;
    logic               accept;
    logic               last_slice;

    assign bus.diff   = diff_q;
    assign bus.borrow = borrow_q;
    assign bus.zero   = zero_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

    // Next-state logic plus the shared slice adder working on the current slice k.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last_slice = 1'b0;
        a_slice    = a_q[k*SLICE_W +: SLICE_W];
        b_slice    = b_q[k*SLICE_W +: SLICE_W];
        slice_sum  = {1'b0, a_slice} + {1'b0, ~b_slice} + {{SLICE_W{1'b0}}, carry};
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (k == KW'(NSLICE - 1)) begin
                    last_slice = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand latching, slice-by-slice result write-back and flag/handshake generation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k        <= '0;
            carry    <= 1'b1;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                a_q    <= bus.a;
                b_q    <= bus.b;
                k      <= '0;
                carry  <= 1'b1;
                busy_q <= 1'b1;
            end
            if (state == RUN) begin
                diff_q[k*SLICE_W +: SLICE_W] <= slice_sum[SLICE_W-1:0];
                carry                        <= slice_sum[SLICE_W];
                k                            <= k + KW'(1);
                if (last_slice) begin
                    borrow_q <= ~slice_sum[SLICE_W];
                    zero_q   <= (diff_q[(NSLICE-1)*SLICE_W-1:0] == '0) &&
                                (slice_sum[SLICE_W-1:0] == '0);
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    k        <= '0;
                end
            end
        end
    end

endmodule
